// File: rtl/muldiv_pkg.sv
// Shared types, opcode constants and funct3 helpers for the iterative RV32M unit.
package muldiv_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StMul,
        StDiv,
        StFix,
        StDone
    } md_state_e;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    function automatic logic f3_is_div(input logic [2:0] f3);
        return f3[2];
    endfunction

    function automatic logic f3_is_rem(input logic [2:0] f3);
        return f3[2] & f3[1];
    endfunction

    // High product half is wanted by every multiply except plain mul
    function automatic logic f3_hi_sel(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_MULHU);
    endfunction

    function automatic logic f3_a_signed(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    function automatic logic f3_b_signed(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// Request/response bundle between the execute stage and the multiply/divide unit.
interface muldiv_seq_if #(
    parameter int unsigned XLEN = 32
) ();
    logic            start;
    logic [6:0]      op;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            flush;
    logic            md_op;
    logic            stall;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, op, funct3, funct7, rs1, rs2, flush,
        input  md_op, stall, busy, done, result
    );

    modport slave (
        input  start, op, funct3, funct7, rs1, rs2, flush,
        output md_op, stall, busy, done, result
    );
endinterface

// File: rtl/md_decode.sv
// Combinational decode of an R-type M-extension instruction into control flags.
module md_decode
    import muldiv_pkg::*;
(
    input  logic [6:0] op_i,
    input  logic [2:0] funct3_i,
    input  logic [6:0] funct7_i,
    output logic       md_op_o,
    output logic       is_div_o,
    output logic       is_rem_o,
    output logic       hi_sel_o,
    output logic       a_signed_o,
    output logic       b_signed_o
);

    // Flag decode from the instruction fields
    always_comb begin
        md_op_o    = (op_i == OP_RTYPE) && (funct7_i == F7_MULDIV);
        is_div_o   = f3_is_div(funct3_i);
        is_rem_o   = f3_is_rem(funct3_i);
        hi_sel_o   = f3_hi_sel(funct3_i);
        a_signed_o = f3_a_signed(funct3_i);
        b_signed_o = f3_b_signed(funct3_i);
    end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative RV32M execute unit: shift-add multiply and restoring divide on
// operand magnitudes, with a final sign fix-up step.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    muldiv_seq_if.slave bus_io
);

    localparam int unsigned     CntW      = $clog2(XLEN);
    localparam logic [XLEN-1:0] SignedMin = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e         state_q, state_d;
    logic [2:0]        f3_q, f3_d;
    logic              hi_sel_q, hi_sel_d;
    logic              neg_q, neg_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic [XLEN-1:0]   result_q, result_d;
    // Multiply: {partial high, multiplier shifting out}; divide: {remainder, quotient}
    logic [2*XLEN-1:0] acc_q, acc_d;

    logic md_op, is_div, is_rem, hi_sel, a_signed, b_signed;

    md_decode u_decode (
        .op_i       (bus_io.op),
        .funct3_i   (bus_io.funct3),
        .funct7_i   (bus_io.funct7),
        .md_op_o    (md_op),
        .is_div_o   (is_div),
        .is_rem_o   (is_rem),
        .hi_sel_o   (hi_sel),
        .a_signed_o (a_signed),
        .b_signed_o (b_signed)
    );

    logic            a_neg, b_neg, accept, div_zero, div_ovf;
    logic [XLEN-1:0] a_abs, b_abs;

    assign a_neg    = a_signed & bus_io.rs1[XLEN-1];
    assign b_neg    = b_signed & bus_io.rs2[XLEN-1];
    assign a_abs    = a_neg ? -bus_io.rs1 : bus_io.rs1;
    assign b_abs    = b_neg ? -bus_io.rs2 : bus_io.rs2;
    // Flush outranks a same-cycle request
    assign accept   = (state_q == StIdle) & bus_io.start & md_op & ~bus_io.flush;
    assign div_zero = is_div & (bus_io.rs2 == '0);
    assign div_ovf  = is_div & a_signed & (bus_io.rs1 == SignedMin) & (bus_io.rs2 == '1);

    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic [2*XLEN-1:0] mul_next, div_next, prod_signed;
    logic [XLEN-1:0]   div_pick, fix_val;

    // One shift-add / restoring step and the final signed result selection
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, b_q};
        mul_next  = acc_q[0] ? {mul_sum, acc_q[XLEN-1:1]} : {1'b0, acc_q[2*XLEN-1:1]};

        // Remainder stays below the divisor, so bit XLEN of the difference is its sign
        div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, b_q};
        if (!div_diff[XLEN]) begin
            div_next = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end else begin
            div_next = {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        end

        // Negate the full product so the high half carries the borrow from the low half
        prod_signed = neg_q ? -acc_q : acc_q;
        div_pick    = f3_is_rem(f3_q) ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
        if (f3_is_div(f3_q)) begin
            fix_val = neg_q ? -div_pick : div_pick;
        end else if (hi_sel_q) begin
            fix_val = prod_signed[2*XLEN-1:XLEN];
        end else begin
            fix_val = prod_signed[XLEN-1:0];
        end
    end

    // Next-state and datapath register updates
    always_comb begin
        state_d  = state_q;
        f3_d     = f3_q;
        hi_sel_d = hi_sel_q;
        neg_d    = neg_q;
        cnt_d    = cnt_q;
        b_d      = b_q;
        acc_d    = acc_q;
        result_d = result_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    f3_d     = bus_io.funct3;
                    hi_sel_d = hi_sel;
                    neg_d    = is_rem ? a_neg : (a_neg ^ b_neg);
                    cnt_d    = CntW'(XLEN - 1);
                    b_d      = b_abs;
                    acc_d    = {{XLEN{1'b0}}, a_abs};
                    if (div_zero) begin
                        result_d = is_rem ? bus_io.rs1 : '1;
                        state_d  = StDone;
                    end else if (div_ovf) begin
                        result_d = is_rem ? '0 : bus_io.rs1;
                        state_d  = StDone;
                    end else begin
                        state_d = is_div ? StDiv : StMul;
                    end
                end
            end
            StMul: begin
                acc_d = mul_next;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) state_d = StFix;
            end
            StDiv: begin
                acc_d = div_next;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) state_d = StFix;
            end
            StFix: begin
                result_d = fix_val;
                state_d  = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Abort drops the operation without touching the visible result
        if (bus_io.flush && (state_q != StIdle)) begin
            state_d  = StIdle;
            result_d = result_q;
        end
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            f3_q     <= '0;
            hi_sel_q <= 1'b0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            f3_q     <= f3_d;
            hi_sel_q <= hi_sel_d;
            neg_q    <= neg_d;
            cnt_q    <= cnt_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

    assign bus_io.md_op  = md_op;
    assign bus_io.stall  = (bus_io.start & md_op & (state_q == StIdle)) |
                           (state_q == StMul) | (state_q == StDiv) | (state_q == StFix);
    assign bus_io.busy   = (state_q != StIdle);
    assign bus_io.done   = (state_q == StDone);
    assign bus_io.result = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed corner cases plus random
// operations checked against an arithmetic reference model.
module tb_muldiv_seq;
    import muldiv_pkg::*;

    localparam int unsigned XLEN = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    muldiv_seq_if #(.XLEN(XLEN)) bus ();

    muldiv_seq #(.XLEN(XLEN)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus_io (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cycle = 0;

    always @(posedge clk) cycle = cycle + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, cycle=%0d required=<100000", cycle);
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Reference: RISC-V M semantics in plain 64-bit arithmetic
    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [63:0]     p;
        int              ia, ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'h0, a};
        ub = {32'h0, b};
        ia = a;
        ib = b;
        case (f3)
            F3_MUL:    begin p = ua * ub;           return p[31:0];  end
            F3_MULH:   begin p = sa * sb;           return p[63:32]; end
            F3_MULHSU: begin p = sa * longint'(ub); return p[63:32]; end
            F3_MULHU:  begin p = ua * ub;           return p[63:32]; end
            F3_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return 32'(ia / ib);
            end
            F3_DIVU: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            F3_REM: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return 32'(ia % ib);
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a,
                                      input logic [31:0] b);
        if (!f3[2]) return 1'b0;
        if (b == 0) return 1'b1;
        return !f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    endfunction

    bit          active = 1'b0;
    int          exp_k, exp_done;
    logic [31:0] exp_res;

    // Per-cycle comparison of DUT outputs against the scoreboard expectation
    always @(negedge clk) begin
        if (rst_n) begin
            check("md_op", bus.md_op, (bus.op == OP_RTYPE) && (bus.funct7 == F7_MULDIV));
            if (active) begin
                if (cycle < exp_done) begin
                    check("stall_run", bus.stall, 1);
                    check("done_early", bus.done, 0);
                    check("busy_run", bus.busy, cycle > exp_k);
                end else begin
                    check("done_pulse", bus.done, 1);
                    check("stall_done", bus.stall, 0);
                    check("busy_done", bus.busy, 1);
                    check("result", bus.result, exp_res);
                    active = 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one request cycle; caller is positioned just after a rising edge
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input bit track);
        bus.start  = 1'b1;
        bus.op     = OP_RTYPE;
        bus.funct7 = F7_MULDIV;
        bus.funct3 = f3;
        bus.rs1    = a;
        bus.rs2    = b;
        if (track) begin
            exp_k    = cycle;
            exp_res  = model(f3, a, b);
            exp_done = cycle + (is_special(f3, a, b) ? 1 : XLEN + 2);
            active   = 1'b1;
        end
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            if (!bus.busy) return;
            tick();
        end
        check("idle_timeout", bus.busy, 0);
    endtask

    task automatic finish_op();
        while (cycle <= exp_done) tick();
        check("done_one_cycle", bus.done, 0);
        check("result_hold", bus.result, exp_res);
    endtask

    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        wait_idle();
        issue(f3, a, b, 1'b1);
        finish_op();
    endtask

    task automatic directed(input string name, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] lit);
        check({name, "_model"}, model(f3, a, b), lit);
        run_op(f3, a, b);
        check(name, bus.result, lit);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            4:       return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    int          k;
    logic [31:0] prior;

    initial begin
        bus.start  = 1'b0;
        bus.op     = 7'h0;
        bus.funct3 = 3'h0;
        bus.funct7 = 7'h0;
        bus.rs1    = '0;
        bus.rs2    = '0;
        bus.flush  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_result", bus.result, 0);
        check("rst_stall", bus.stall, 0);
        rst_n = 1'b1;
        tick();

        directed("mul", F3_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
        directed("mulh", F3_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        directed("mulhu", F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        directed("mulhsu", F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        directed("div", F3_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        directed("rem", F3_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        directed("divu", F3_DIVU, 32'd100, 32'd7, 32'd14);
        directed("remu", F3_REMU, 32'd100, 32'd7, 32'd2);
        directed("div_by0", F3_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF);
        directed("rem_by0", F3_REM, 32'd5, 32'd0, 32'd5);
        directed("div_ovf", F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        directed("rem_ovf", F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);

        // Flush in the middle of a multiply, then restart immediately
        wait_idle();
        prior = bus.result;
        k = cycle;
        issue(F3_MULHU, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
        while (cycle < k + 10) begin
            check("flush_no_done", bus.done, 0);
            tick();
        end
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("flush_idle", bus.busy, 0);
        check("flush_done", bus.done, 0);
        check("flush_result", bus.result, prior);
        issue(F3_DIVU, 32'd1000, 32'd7, 1'b1);
        finish_op();

        // Flush in the same cycle as a request wins
        wait_idle();
        prior = bus.result;
        bus.flush = 1'b1;
        issue(F3_MUL, 32'd3, 32'd5, 1'b0);
        bus.flush = 1'b0;
        check("flush_start_busy", bus.busy, 0);
        check("flush_start_result", bus.result, prior);

        // Reset mid-operation clears everything
        wait_idle();
        k = cycle;
        issue(F3_DIV, 32'd1000, 32'd3, 1'b0);
        while (cycle < k + 5) tick();
        rst_n = 1'b0;
        bus.op = 7'h0;
        tick();
        check("rst_mid_busy", bus.busy, 0);
        check("rst_mid_done", bus.done, 0);
        check("rst_mid_result", bus.result, 0);
        check("rst_mid_stall", bus.stall, 0);
        check("rst_mid_md_op", bus.md_op, 0);
        rst_n = 1'b1;
        tick();

        // sub (funct7 = 0100000) is not ours
        prior = bus.result;
        bus.start  = 1'b1;
        bus.op     = OP_RTYPE;
        bus.funct7 = 7'b0100000;
        bus.funct3 = F3_MUL;
        bus.rs1    = 32'd9;
        bus.rs2    = 32'd9;
        #1;
        check("sub_md_op", bus.md_op, 0);
        check("sub_stall", bus.stall, 0);
        tick();
        bus.start = 1'b0;
        check("sub_busy", bus.busy, 0);
        check("sub_result", bus.result, prior);

        // A second request while busy is ignored
        wait_idle();
        issue(F3_DIVU, 32'd1000, 32'd7, 1'b1);
        tick();
        issue(F3_MUL, 32'd3, 32'd5, 1'b0);
        finish_op();
        check("busy_ignore", bus.result, 32'd142);

        for (int i = 0; i < 40; i++) begin
            logic [2:0]  f3;
            logic [31:0] a, b;
            f3 = 3'($urandom_range(0, 7));
            a  = pick();
            b  = pick();
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick();
            run_op(f3, a, b);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
